// File: rtl/can_ctrl_mb_pkg.sv
// Shared definitions for the CAN mailbox controller: bus-state encoding,
// default DMA address constants and small elaboration helpers.
package can_ctrl_mb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START_RX = 3'd1,
        ST_RX       = 3'd2,
        ST_START_TX = 3'd3,
        ST_TX       = 3'd4,
        ST_PAUSE    = 3'd5
    } bus_state_t;

    localparam int          FRAME_BITS       = 64;
    localparam int          DEF_ADDR_WIDTH   = 20;
    localparam logic [19:0] DEF_RX_BASE_ADDR = 20'hB0002;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/can_rx_dma.sv
// One-frame receive buffer drained to the DMA port as 64/DATA_WIDTH words,
// most-significant word first, one outstanding write at a time.
module can_rx_dma
    import can_ctrl_mb_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RX_BASE_ADDR = ADDR_WIDTH'(DEF_RX_BASE_ADDR)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rx_frame_ready_i,
    input  logic [63:0]           rx_data_i,
    output logic [DATA_WIDTH-1:0] data_wr,
    output logic [ADDR_WIDTH-1:0] addr_wr,
    output logic                  wr_en,
    input  logic                  wr_done,
    input  logic                  wr_busy,
    output logic                  rx_overrun_o
);

    localparam int             NUM_WORDS = FRAME_BITS / DATA_WIDTH;
    localparam int             WW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [WW-1:0]  LAST_WORD = WW'(NUM_WORDS - 1);

    logic                  r_full;
    logic [63:0]           r_buf;
    logic [WW-1:0]         r_word;
    logic                  r_wr_en;
    logic [DATA_WIDTH-1:0] r_data_wr;
    logic [ADDR_WIDTH-1:0] r_addr_wr;
    logic                  r_overrun;

    logic                  w_word_done;
    logic                  w_free;
    logic [63:0]           w_shifted;
    logic [DATA_WIDTH-1:0] w_word;

    assign w_word_done = r_wr_en & wr_done;
    assign w_free      = w_word_done & (r_word == LAST_WORD);
    assign w_shifted   = r_buf << (int'(r_word) * DATA_WIDTH);
    assign w_word      = w_shifted[63 -: DATA_WIDTH];

    // NOTE: non-blocking assignments only, so every register here samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_full    <= 1'b0;
            r_buf     <= '0;
            r_word    <= '0;
            r_wr_en   <= 1'b0;
            r_data_wr <= '0;
            r_addr_wr <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;

            // A word is fully retired before the next one is presented.
            if (w_word_done) begin
                r_wr_en <= 1'b0;
                if (w_free) r_full <= 1'b0;
                else        r_word <= r_word + 1'b1;
            end else if (r_full && !r_wr_en && !wr_busy) begin
                r_wr_en   <= 1'b1;
                r_data_wr <= w_word;
                r_addr_wr <= RX_BASE_ADDR + ADDR_WIDTH'(r_word);
            end

            if (rx_frame_ready_i) begin
                if (!r_full || w_free) begin
                    r_buf  <= rx_data_i;
                    r_full <= 1'b1;
                    r_word <= '0;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign data_wr      = r_data_wr;
    assign addr_wr      = r_addr_wr;
    assign wr_en        = r_wr_en;
    assign rx_overrun_o = r_overrun;

endmodule

// File: rtl/can_ctrl_mb.sv
// CAN controller core: transmit mailboxes with retry/backoff arbitration
// against a receive path, plus an independent receive-to-DMA sequencer.
module can_ctrl_mb
    import can_ctrl_mb_pkg::*;
#(
    parameter int                    NUM_MB       = 4,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RX_BASE_ADDR = ADDR_WIDTH'(DEF_RX_BASE_ADDR),
    parameter int                    PAUSE_BITS   = 3,
    parameter int                    BACKOFF_BITS = 11,
    parameter int                    MAX_RETRY    = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  bit_tick_i,
    input  logic [NUM_MB-1:0]     mb_load_i,
    input  logic [63:0]           mb_data_i,
    output logic [NUM_MB-1:0]     mb_pending_o,
    output logic [NUM_MB-1:0]     mb_done_o,
    output logic [NUM_MB-1:0]     mb_fail_o,
    output logic                  tx_start_o,
    output logic [63:0]           tx_data_o,
    input  logic                  tx_busy_i,
    input  logic                  tx_frame_sent_i,
    input  logic                  tx_lost_arb_i,
    input  logic                  tx_ack_i,
    output logic                  rx_start_o,
    input  logic                  rx_busy_i,
    input  logic                  rx_frame_ready_i,
    input  logic [63:0]           rx_data_i,
    output logic [DATA_WIDTH-1:0] data_wr,
    output logic [ADDR_WIDTH-1:0] addr_wr,
    output logic                  wr_en,
    input  logic                  wr_done,
    input  logic                  wr_busy,
    output logic                  rx_overrun_o,
    output logic [2:0]            state_o
);

    localparam int             AW          = (NUM_MB > 1) ? $clog2(NUM_MB) : 1;
    localparam int             RW          = $clog2(MAX_RETRY + 1);
    localparam int             PW          = $clog2(max_int(PAUSE_BITS, BACKOFF_BITS) + 1);
    localparam logic [PW-1:0]  PAUSE_LEN   = PW'(PAUSE_BITS);
    localparam logic [PW-1:0]  BACKOFF_LEN = PW'(BACKOFF_BITS);
    localparam logic [RW-1:0]  RETRY_LIMIT = RW'(MAX_RETRY);

    bus_state_t        r_state;
    logic              r_tx_start;
    logic              r_rx_start;
    logic [AW-1:0]     r_active;
    logic [63:0]       r_tx_data;
    logic [NUM_MB-1:0] r_pending;
    logic [NUM_MB-1:0] r_done;
    logic [NUM_MB-1:0] r_fail;
    logic [63:0]       r_mb_data [NUM_MB];
    logic [RW-1:0]     r_retry   [NUM_MB];
    logic [PW-1:0]     r_pause_cnt;
    logic [PW-1:0]     r_pause_len;
    logic              r_tick_seen;

    logic [AW-1:0]     w_next_mb;
    logic              w_any_pending;
    logic              w_lock;
    logic [63:0]       w_next_data;
    logic [RW-1:0]     w_retry_inc;
    logic [PW-1:0]     w_pause_inc;

    // NOTE: w_next_mb gets its default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_mb = '0;
        for (int k = NUM_MB - 1; k >= 0; k--) begin
            if (r_pending[k]) w_next_mb = AW'(k);
        end
    end

    assign w_any_pending = |r_pending;
    assign w_lock        = (r_state == ST_START_TX) || (r_state == ST_TX);
    // A load landing on the selected mailbox in the selection cycle is what gets sent.
    assign w_next_data   = mb_load_i[w_next_mb] ? mb_data_i : r_mb_data[w_next_mb];
    assign w_retry_inc   = r_retry[r_active] + 1'b1;
    assign w_pause_inc   = r_pause_cnt + 1'b1;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= ST_IDLE;
            r_tx_start  <= 1'b0;
            r_rx_start  <= 1'b0;
            r_active    <= '0;
            r_tx_data   <= '0;
            r_pending   <= '0;
            r_done      <= '0;
            r_fail      <= '0;
            r_pause_cnt <= '0;
            r_pause_len <= '0;
            r_tick_seen <= 1'b0;
            // NOTE: mailbox storage is reset on purpose: stale payloads must not survive a reset.
            for (int k = 0; k < NUM_MB; k++) begin
                r_mb_data[k] <= '0;
                r_retry[k]   <= '0;
            end
        end else begin
            r_done <= '0;
            r_fail <= '0;

            for (int k = 0; k < NUM_MB; k++) begin
                if (mb_load_i[k] && !(w_lock && r_active == AW'(k))) begin
                    r_mb_data[k] <= mb_data_i;
                    r_pending[k] <= 1'b1;
                    r_retry[k]   <= '0;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_any_pending) begin
                        r_state     <= ST_START_TX;
                        r_tx_start  <= 1'b1;
                        r_active    <= w_next_mb;
                        r_tx_data   <= w_next_data;
                        r_tick_seen <= 1'b0;
                    end else begin
                        r_state    <= ST_START_RX;
                        r_rx_start <= 1'b1;
                    end
                end
                ST_START_RX: begin
                    if (rx_busy_i) begin
                        r_state <= ST_RX;
                    end else begin
                        r_state    <= ST_IDLE;
                        r_rx_start <= 1'b0;
                    end
                end
                ST_RX: begin
                    if (!rx_busy_i) begin
                        r_rx_start  <= 1'b0;
                        r_state     <= ST_PAUSE;
                        r_pause_cnt <= '0;
                        r_pause_len <= PAUSE_LEN;
                    end
                end
                ST_START_TX: begin
                    // Give the transmitter two bit times to respond before backing out.
                    if (tx_busy_i) begin
                        r_state <= ST_TX;
                    end else if (bit_tick_i) begin
                        if (r_tick_seen) begin
                            r_state    <= ST_IDLE;
                            r_tx_start <= 1'b0;
                        end else begin
                            r_tick_seen <= 1'b1;
                        end
                    end
                end
                ST_TX: begin
                    if (tx_frame_sent_i && tx_ack_i) begin
                        r_pending[r_active] <= 1'b0;
                        r_retry[r_active]   <= '0;
                        r_done[r_active]    <= 1'b1;
                        r_tx_start          <= 1'b0;
                        r_state             <= ST_PAUSE;
                        r_pause_cnt         <= '0;
                        r_pause_len         <= PAUSE_LEN;
                    end else if (tx_lost_arb_i || tx_frame_sent_i) begin
                        r_tx_start  <= 1'b0;
                        r_state     <= ST_PAUSE;
                        r_pause_cnt <= '0;
                        r_pause_len <= BACKOFF_LEN;
                        if (w_retry_inc == RETRY_LIMIT) begin
                            r_pending[r_active] <= 1'b0;
                            r_fail[r_active]    <= 1'b1;
                            r_retry[r_active]   <= '0;
                        end else begin
                            r_retry[r_active] <= w_retry_inc;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (bit_tick_i) begin
                        r_pause_cnt <= w_pause_inc;
                        if (w_pause_inc == r_pause_len) r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mb_pending_o = r_pending;
    assign mb_done_o    = r_done;
    assign mb_fail_o    = r_fail;
    assign tx_start_o   = r_tx_start;
    assign tx_data_o    = r_tx_data;
    assign rx_start_o   = r_rx_start;
    assign state_o      = r_state;

    can_rx_dma #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .RX_BASE_ADDR (RX_BASE_ADDR)
    ) u_rx_dma (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .rx_frame_ready_i (rx_frame_ready_i),
        .rx_data_i        (rx_data_i),
        .data_wr          (data_wr),
        .addr_wr          (addr_wr),
        .wr_en            (wr_en),
        .wr_done          (wr_done),
        .wr_busy          (wr_busy),
        .rx_overrun_o     (rx_overrun_o)
    );

endmodule

// File: tb/tb_can_ctrl_mb.sv
// Directed bench for can_ctrl_mb: scoreboards for done/fail pulses, pause
// lengths and DMA words, with a simple transmitter and DMA responder.
module tb_can_ctrl_mb;

    localparam int NUM_MB = 4;
    localparam int DW     = 32;
    localparam int AWID   = 20;

    localparam int OUT_ACK  = 0;
    localparam int OUT_LOST = 2;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              bit_tick_i = 1'b0;
    logic [NUM_MB-1:0] mb_load_i = '0;
    logic [63:0]       mb_data_i = '0;
    logic [NUM_MB-1:0] mb_pending_o, mb_done_o, mb_fail_o;
    logic              tx_start_o;
    logic [63:0]       tx_data_o;
    logic              tx_busy_i = 1'b0, tx_frame_sent_i = 1'b0, tx_lost_arb_i = 1'b0, tx_ack_i = 1'b0;
    logic              rx_start_o;
    logic              rx_busy_i = 1'b0, rx_frame_ready_i = 1'b0;
    logic [63:0]       rx_data_i = '0;
    logic [DW-1:0]     data_wr;
    logic [AWID-1:0]   addr_wr;
    logic              wr_en;
    logic              wr_done = 1'b0, wr_busy = 1'b0;
    logic              rx_overrun_o;
    logic [2:0]        state_o;

    can_ctrl_mb dut (
        .clk_i(clk_i), .rst_i(rst_i), .bit_tick_i(bit_tick_i),
        .mb_load_i(mb_load_i), .mb_data_i(mb_data_i),
        .mb_pending_o(mb_pending_o), .mb_done_o(mb_done_o), .mb_fail_o(mb_fail_o),
        .tx_start_o(tx_start_o), .tx_data_o(tx_data_o),
        .tx_busy_i(tx_busy_i), .tx_frame_sent_i(tx_frame_sent_i),
        .tx_lost_arb_i(tx_lost_arb_i), .tx_ack_i(tx_ack_i),
        .rx_start_o(rx_start_o), .rx_busy_i(rx_busy_i),
        .rx_frame_ready_i(rx_frame_ready_i), .rx_data_i(rx_data_i),
        .data_wr(data_wr), .addr_wr(addr_wr), .wr_en(wr_en),
        .wr_done(wr_done), .wr_busy(wr_busy),
        .rx_overrun_o(rx_overrun_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    logic [NUM_MB-1:0] done_q  [$];
    logic [NUM_MB-1:0] fail_q  [$];
    int                pause_q [$];
    logic [51:0]       dma_q   [$];
    int                dma_delay   = 5;
    int                overrun_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctrl"}, {mb_pending_o, mb_done_o, mb_fail_o, tx_start_o, rx_start_o,
                               wr_en, rx_overrun_o, state_o}, '0);
        check({tag, "_tx_data"}, tx_data_o, '0);
        check({tag, "_dma_bus"}, {addr_wr, data_wr}, '0);
    endtask

    // Bit tick every fourth clock.
    int tick_div = 0;
    initial forever begin
        @(posedge clk_i);
        #1;
        tick_div   = tick_div + 1;
        bit_tick_i = (tick_div % 4 == 0);
    end

    initial forever begin
        @(negedge clk_i);
        if (mb_done_o !== '0)
            check("mb_done", mb_done_o, (done_q.size() != 0) ? done_q.pop_front() : '0);
        if (mb_fail_o !== '0)
            check("mb_fail", mb_fail_o, (fail_q.size() != 0) ? fail_q.pop_front() : '0);
        if (rx_overrun_o) overrun_cnt++;
    end

    int pcnt = 0;
    bit in_pause = 1'b0;
    initial forever begin
        @(negedge clk_i);
        if (!rst_i) begin
            in_pause = 1'b0;
            pcnt     = 0;
        end else if (state_o == 3'd5) begin
            in_pause = 1'b1;
            if (bit_tick_i) pcnt++;
        end else if (in_pause) begin
            in_pause = 1'b0;
            check("pause_len", pcnt, (pause_q.size() != 0) ? pause_q.pop_front() : -1);
            pcnt = 0;
        end
    end

    // DMA responder: wr_done after dma_delay cycles, checking the word is held.
    logic [51:0] dma_exp, dma_held;
    bit          dma_abort;
    initial forever begin
        @(negedge clk_i);
        if (rst_i && wr_en) begin
            dma_exp = (dma_q.size() != 0) ? dma_q.pop_front() : '0;
            check("dma_word", {addr_wr, data_wr}, dma_exp);
            dma_held  = {addr_wr, data_wr};
            dma_abort = 1'b0;
            for (int i = 0; i < dma_delay; i++) begin
                @(negedge clk_i);
                if (!rst_i) begin
                    dma_abort = 1'b1;
                    break;
                end
                check("dma_hold", {wr_en, addr_wr, data_wr}, {1'b1, dma_held});
            end
            if (!dma_abort) begin
                @(posedge clk_i);
                #1 wr_done = 1'b1;
                @(posedge clk_i);
                #1 wr_done = 1'b0;
            end
        end
    end

    task automatic load_mb(input logic [NUM_MB-1:0] mask, input logic [63:0] data);
        mb_data_i = data;
        mb_load_i = mask;
        step();
        mb_load_i = '0;
    endtask

    task automatic tx_begin(input logic [63:0] exp_data);
        for (int i = 0; i < 300 && !tx_start_o; i++) step();
        check("tx_start_seen", tx_start_o, 1'b1);
        check("tx_data", tx_data_o, exp_data);
        check("state_start_tx", state_o, 3'd3);
        tx_busy_i = 1'b1;
        step();
        check("state_tx", state_o, 3'd4);
    endtask

    task automatic tx_end(input int outcome);
        if (outcome == OUT_LOST) begin
            tx_lost_arb_i = 1'b1;
        end else begin
            tx_frame_sent_i = 1'b1;
            tx_ack_i        = (outcome == OUT_ACK);
        end
        step();
        tx_lost_arb_i   = 1'b0;
        tx_frame_sent_i = 1'b0;
        tx_ack_i        = 1'b0;
        tx_busy_i       = 1'b0;
        check("tx_start_dropped", {tx_start_o, state_o}, {1'b0, 3'd5});
    endtask

    task automatic wait_bus_quiet();
        for (int i = 0; i < 200 && (pause_q.size() != 0 || state_o == 3'd5); i++) step();
        check("pause_drained", {pause_q.size() != 0, state_o == 3'd5}, '0);
    endtask

    task automatic send_frame(input logic [63:0] data, input bit expect_dma);
        rx_data_i        = data;
        rx_frame_ready_i = 1'b1;
        if (expect_dma) begin
            dma_q.push_back({20'hB0002, data[63:32]});
            dma_q.push_back({20'hB0003, data[31:0]});
        end
        step();
        rx_frame_ready_i = 1'b0;
    endtask

    task automatic wait_dma_idle();
        for (int i = 0; i < 200 && (dma_q.size() != 0 || wr_en); i++) step();
        check("dma_drained", {dma_q.size() != 0, wr_en}, '0);
    endtask

    int  ov0;
    bit  seen;

    initial begin
        steps(2);
        check_zero("reset");
        rst_i = 1'b1;
        steps(3);

        // Two mailboxes loaded together: lowest index first, same payload.
        load_mb(4'b0101, 64'hA1A2_A3A4_A5A6_A7A8);
        check("s1_pending", mb_pending_o, 4'b0101);
        done_q.push_back(4'b0001);
        pause_q.push_back(3);
        tx_begin(64'hA1A2_A3A4_A5A6_A7A8);
        tx_end(OUT_ACK);
        done_q.push_back(4'b0100);
        pause_q.push_back(3);
        tx_begin(64'hA1A2_A3A4_A5A6_A7A8);
        tx_end(OUT_ACK);
        wait_bus_quiet();
        check("s1_pending_after", mb_pending_o, '0);

        // Lost arbitration on every attempt until the mailbox is dropped.
        load_mb(4'b0001, 64'hB0B1_B2B3_B4B5_B6B7);
        for (int a = 0; a < 15; a++) begin
            pause_q.push_back(11);
            if (a == 14) fail_q.push_back(4'b0001);
            tx_begin(64'hB0B1_B2B3_B4B5_B6B7);
            tx_end(OUT_LOST);
            if (a == 13) check("s2_still_pending", mb_pending_o, 4'b0001);
        end
        wait_bus_quiet();
        check("s2_pending_dropped", mb_pending_o, '0);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (tx_start_o) seen = 1'b1;
        end
        check("s2_no_more_attempts", seen, 1'b0);

        // Receive frame drained as two words with a slow wr_done.
        ov0 = overrun_cnt;
        send_frame(64'h1122334455667788, 1'b1);
        wait_dma_idle();
        check("s3_no_overrun", overrun_cnt - ov0, 0);

        // Second frame while the buffer is full is dropped.
        ov0 = overrun_cnt;
        send_frame(64'hCAFE_0001_BEEF_0002, 1'b1);
        steps(2);
        send_frame(64'hDEAD_DEAD_DEAD_DEAD, 1'b0);
        wait_dma_idle();
        steps(20);
        check("s4_overrun_once", overrun_cnt - ov0, 1);
        check("s4_no_stray_write", wr_en, 1'b0);

        // Reload of the in-flight mailbox is ignored; after done it is accepted.
        load_mb(4'b0010, 64'h5555_0000_5555_0001);
        done_q.push_back(4'b0010);
        pause_q.push_back(3);
        tx_begin(64'h5555_0000_5555_0001);
        load_mb(4'b0010, 64'h6666_0000_6666_0001);
        check("s5_tx_data_kept", tx_data_o, 64'h5555_0000_5555_0001);
        check("s5_state_still_tx", state_o, 3'd4);
        tx_end(OUT_ACK);
        check("s5_pending_cleared", mb_pending_o, '0);
        load_mb(4'b0010, 64'h6666_0000_6666_0001);
        check("s5_reload_accepted", mb_pending_o, 4'b0010);
        done_q.push_back(4'b0010);
        pause_q.push_back(3);
        tx_begin(64'h6666_0000_6666_0001);
        tx_end(OUT_ACK);
        wait_bus_quiet();

        // Transmitter never responds: request withdrawn, mailbox kept.
        load_mb(4'b0100, 64'h7777_7777_0000_0007);
        for (int i = 0; i < 50 && !tx_start_o; i++) step();
        for (int i = 0; i < 20 && tx_start_o; i++) step();
        check("timeout_drop", {tx_start_o, state_o}, {1'b0, 3'd0});
        check("timeout_pending", mb_pending_o, 4'b0100);
        done_q.push_back(4'b0100);
        pause_q.push_back(3);
        tx_begin(64'h7777_7777_0000_0007);
        tx_end(OUT_ACK);
        wait_bus_quiet();

        // Reset in the middle of a transmission.
        load_mb(4'b1000, 64'h8888_8888_8888_8888);
        tx_begin(64'h8888_8888_8888_8888);
        rst_i = 1'b0;
        #1;
        check_zero("s6_tx_reset");
        tx_busy_i = 1'b0;
        step();
        rst_i = 1'b1;
        steps(20);
        check("s6_mailbox_abandoned", mb_pending_o, '0);

        // Reset in the middle of a DMA transfer.
        rx_data_i        = 64'h9999_0001_9999_0002;
        rx_frame_ready_i = 1'b1;
        dma_q.push_back({20'hB0002, 32'h9999_0001});
        step();
        rx_frame_ready_i = 1'b0;
        for (int i = 0; i < 20 && !wr_en; i++) step();
        check("s6_dma_started", wr_en, 1'b1);
        steps(2);
        rst_i = 1'b0;
        #1;
        check_zero("s6_dma_reset");
        dma_q.delete();
        step();
        rst_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (wr_en) seen = 1'b1;
        end
        check("s6_dma_abandoned", seen, 1'b0);

        check("queues_empty", done_q.size() + fail_q.size() + pause_q.size() + dma_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
